// File: rtl/wb_arbiter_scalar.sv
// rtl/wb_arbiter_scalar.sv - writeback arbiter for the scalar register file write port
//
// wb_arbiter_scalar_fifo : small result buffer with a valid/ready stream on each side
//   in_tvalid/in_tready/in_tdata    : push side; transfer when both valid and ready at posedge
//   out_tvalid/out_tready/out_tdata : pop side; out_tdata is the head entry
//
// wb_arbiter_scalar : merges ALU and memory results onto one register-file write port
//   clk, rst                       : clock, asynchronous active-high reset
//   alu_valid/alu_rd/alu_data      : single-cycle ALU result, always accepted
//   ld_issue/ld_issue_rd           : load issued this cycle, marks its rd pending
//   mem_valid/mem_rd/mem_data      : memory result offered
//   mem_ready                      : buffer has room (registered count only)
//   wre/a3/wd3                     : registered register-file write port
//   busy                           : pending-load scoreboard, one bit per register
//   sb_err                         : sticky scoreboard error

module wb_arbiter_scalar_fifo #(
  parameter int W     = 20,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_tvalid,
  output logic         in_tready,
  input  logic [W-1:0] in_tdata,
  output logic         out_tvalid,
  input  logic         out_tready,
  output logic [W-1:0] out_tdata
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];
  logic             push;
  logic             pop;

  // Status comes only from registered count, so ready/valid never depend
  // combinationally on the opposite side of the buffer.
  assign in_tready  = (count_q < CNT_W'(DEPTH));
  assign out_tvalid = (count_q != '0);
  assign out_tdata  = mem_q[rd_ptr_q];

  assign push = in_tvalid && in_tready;
  assign pop  = out_tvalid && out_tready;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = in_tdata;
      // DEPTH is a power of two, so the natural pointer overflow is the wrap.
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

endmodule

module wb_arbiter_scalar #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 4,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alu_valid,
  input  logic [ADDR_W-1:0]        alu_rd,
  input  logic [DATA_W-1:0]        alu_data,
  input  logic                     ld_issue,
  input  logic [ADDR_W-1:0]        ld_issue_rd,
  input  logic                     mem_valid,
  input  logic [ADDR_W-1:0]        mem_rd,
  input  logic [DATA_W-1:0]        mem_data,
  output logic                     mem_ready,
  output logic                     wre,
  output logic [ADDR_W-1:0]        a3,
  output logic [DATA_W-1:0]        wd3,
  output logic [(1<<ADDR_W)-1:0]   busy,
  output logic                     sb_err
);

  localparam int SB_W = 1 << ADDR_W;
  localparam int EW   = ADDR_W + DATA_W;

  logic              wre_q, wre_d;
  logic [ADDR_W-1:0] a3_q, a3_d;
  logic [DATA_W-1:0] wd3_q, wd3_d;
  logic [SB_W-1:0]   busy_q, busy_d;
  logic              sb_err_q, sb_err_d;

  logic              head_valid;
  logic [EW-1:0]     head;
  logic [ADDR_W-1:0] head_rd;
  logic [DATA_W-1:0] head_data;
  logic              pop;
  logic [SB_W-1:0]   set_vec;
  logic [SB_W-1:0]   clr_vec;
  logic              err_reissue;
  logic              err_orphan;

  // The ALU path cannot stall, so the buffer only drains on cycles without
  // an ALU result; that is the whole priority scheme.
  wb_arbiter_scalar_fifo #(
    .W     (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_mem_fifo (
    .clk        (clk),
    .rst        (rst),
    .in_tvalid  (mem_valid),
    .in_tready  (mem_ready),
    .in_tdata   ({mem_rd, mem_data}),
    .out_tvalid (head_valid),
    .out_tready (!alu_valid),
    .out_tdata  (head)
  );

  assign head_rd   = head[EW-1 -: ADDR_W];
  assign head_data = head[DATA_W-1:0];
  assign pop       = head_valid && !alu_valid;

  assign set_vec = ld_issue ? (SB_W'(1) << ld_issue_rd) : '0;
  assign clr_vec = pop      ? (SB_W'(1) << head_rd)     : '0;

  // Re-issuing to a register is fine only when its pending result retires
  // in this same cycle.
  assign err_reissue = ld_issue && busy_q[ld_issue_rd] &&
                       !(pop && (head_rd == ld_issue_rd));
  assign err_orphan  = pop && !busy_q[head_rd];

  always_comb begin
    wre_d = 1'b0;
    a3_d  = a3_q;
    wd3_d = wd3_q;
    if (alu_valid) begin
      wre_d = 1'b1;
      a3_d  = alu_rd;
      wd3_d = alu_data;
    end else if (pop) begin
      wre_d = 1'b1;
      a3_d  = head_rd;
      wd3_d = head_data;
    end
  end

  always_comb begin
    // Set applied after clear so a same-cycle set of the retiring register wins.
    busy_d   = (busy_q & ~clr_vec) | set_vec;
    sb_err_d = sb_err_q | err_reissue | err_orphan;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wre_q    <= 1'b0;
      a3_q     <= '0;
      wd3_q    <= '0;
      busy_q   <= '0;
      sb_err_q <= 1'b0;
    end else begin
      wre_q    <= wre_d;
      a3_q     <= a3_d;
      wd3_q    <= wd3_d;
      busy_q   <= busy_d;
      sb_err_q <= sb_err_d;
    end
  end

  assign wre    = wre_q;
  assign a3     = a3_q;
  assign wd3    = wd3_q;
  assign busy   = busy_q;
  assign sb_err = sb_err_q;

endmodule

// File: tb/tb_wb_arbiter_scalar.sv
// tb/tb_wb_arbiter_scalar.sv - self-checking bench for wb_arbiter_scalar
module tb_wb_arbiter_scalar;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        alu_valid = 1'b0;
  logic [3:0]  alu_rd = '0;
  logic [15:0] alu_data = '0;
  logic        ld_issue = 1'b0;
  logic [3:0]  ld_issue_rd = '0;
  logic        mem_valid = 1'b0;
  logic [3:0]  mem_rd = '0;
  logic [15:0] mem_data = '0;
  logic        mem_ready;
  logic        wre;
  logic [3:0]  a3;
  logic [15:0] wd3;
  logic [15:0] busy;
  logic        sb_err;

  wb_arbiter_scalar #(.DATA_W(16), .ADDR_W(4), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_issue(ld_issue), .ld_issue_rd(ld_issue_rd),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data),
    .mem_ready(mem_ready),
    .wre(wre), .a3(a3), .wd3(wd3), .busy(busy), .sb_err(sb_err)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [3:0] rd; logic [15:0] data; } ent_t;

  // Reference model: an ordered list of buffered results, a per-register
  // pending flag, and the last write presented to the register file.
  ent_t        mq[$];
  bit          mbusy[16];
  bit          m_err;
  logic        e_wre;
  logic [3:0]  e_a3;
  logic [15:0] e_wd3;
  bit          last_push;

  int n_vec = 0;
  int n_err = 0;

  function automatic logic [15:0] mbusy_vec();
    logic [15:0] v = '0;
    for (int r = 0; r < 16; r++) v[r] = mbusy[r];
    return v;
  endfunction

  function automatic logic e_ready();
    return (mq.size() < DEPTH);
  endfunction

  task automatic model_clear();
    mq.delete();
    for (int r = 0; r < 16; r++) mbusy[r] = 0;
    m_err = 0; e_wre = 0; e_a3 = '0; e_wd3 = '0; last_push = 0;
  endtask

  // Drives one cycle of inputs, advances the model by the arbitration rules,
  // then returns 1ns after the edge so outputs can be sampled.
  task automatic tick(input bit av, input logic [3:0] ar, input logic [15:0] ad,
                      input bit li, input logic [3:0] lr,
                      input bit mv, input logic [3:0] mr, input logic [15:0] md);
    ent_t h;
    bit do_pop, do_push;
    alu_valid = av; alu_rd = ar; alu_data = ad;
    ld_issue = li; ld_issue_rd = lr;
    mem_valid = mv; mem_rd = mr; mem_data = md;
    h = '0;
    do_pop  = !av && (mq.size() > 0);
    do_push = mv && (mq.size() < DEPTH);
    if (do_pop) h = mq[0];
    if (li && mbusy[lr] && !(do_pop && h.rd == lr)) m_err = 1;
    if (do_pop && !mbusy[h.rd]) m_err = 1;
    if (do_pop) mbusy[h.rd] = 0;
    if (li) mbusy[lr] = 1;
    if (av) begin e_wre = 1; e_a3 = ar; e_wd3 = ad; end
    else if (do_pop) begin e_wre = 1; e_a3 = h.rd; e_wd3 = h.data; end
    else e_wre = 0;
    if (do_pop) void'(mq.pop_front());
    if (do_push) mq.push_back({mr, md});
    last_push = do_push;
    @(posedge clk); #1;
  endtask

  task automatic idle();
    tick(0, 4'd0, 16'h0, 0, 4'd0, 0, 4'd0, 16'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    alu_valid = 0; ld_issue = 0; mem_valid = 0;
    model_clear();
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    model_clear();
    n_vec++;
    if (wre !== 1'b0 || a3 !== 4'd0 || wd3 !== 16'h0 || busy !== 16'h0 ||
        sb_err !== 1'b0 || mem_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_state: wre=%b a3=%0d wd3=%h busy=%h err=%b rdy=%b, required 0 0 0000 0000 0 1",
               wre, a3, wd3, busy, sb_err, mem_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_alu_only();
    do_reset();
    tick(1, 4'd3, 16'h1234, 0, 4'd0, 0, 4'd0, 16'h0);
    n_vec++;
    if (wre !== 1'b1 || a3 !== 4'd3 || wd3 !== 16'h1234) begin
      n_err++;
      $display("FAIL alu_write: wre=%b a3=%0d wd3=%h, required 1 3 1234", wre, a3, wd3);
    end
    idle();
    n_vec++;
    if (wre !== 1'b0 || a3 !== 4'd3 || wd3 !== 16'h1234) begin
      n_err++;
      $display("FAIL alu_idle_hold: wre=%b a3=%0d wd3=%h, required 0 3 1234", wre, a3, wd3);
    end
  endtask

  task automatic test_load_round_trip();
    do_reset();
    tick(0, 4'd0, 16'h0, 1, 4'd5, 0, 4'd0, 16'h0);
    n_vec++;
    if (busy !== 16'h0020) begin
      n_err++;
      $display("FAIL load_busy_set: busy=%h, required 0020", busy);
    end
    idle();
    tick(0, 4'd0, 16'h0, 0, 4'd0, 1, 4'd5, 16'hBEEF);
    n_vec++;
    if (wre !== 1'b0 || busy !== 16'h0020) begin
      n_err++;
      $display("FAIL load_enqueue_edge: wre=%b busy=%h, required 0 0020", wre, busy);
    end
    idle();
    n_vec++;
    if (wre !== 1'b1 || a3 !== 4'd5 || wd3 !== 16'hBEEF || busy !== 16'h0 || sb_err !== 1'b0) begin
      n_err++;
      $display("FAIL load_writeback: wre=%b a3=%0d wd3=%h busy=%h err=%b, required 1 5 beef 0000 0",
               wre, a3, wd3, busy, sb_err);
    end
  endtask

  task automatic test_collision();
    logic [3:0] seq_a3[3];
    logic [3:0] req_a3[3];
    req_a3[0] = 4'd7; req_a3[1] = 4'd7; req_a3[2] = 4'd2;
    do_reset();
    tick(0, 4'd0, 16'h0, 1, 4'd2, 0, 4'd0, 16'h0);
    tick(0, 4'd0, 16'h0, 0, 4'd0, 1, 4'd2, 16'hC0DE);
    tick(1, 4'd7, 16'h0101, 0, 4'd0, 0, 4'd0, 16'h0); seq_a3[0] = a3;
    tick(1, 4'd7, 16'h0202, 0, 4'd0, 0, 4'd0, 16'h0); seq_a3[1] = a3;
    idle(); seq_a3[2] = a3;
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if (seq_a3[i] !== req_a3[i]) begin
        n_err++;
        $display("FAIL collision_order[%0d]: a3=%0d, required %0d", i, seq_a3[i], req_a3[i]);
      end
    end
    n_vec++;
    if (wre !== 1'b1 || wd3 !== 16'hC0DE || busy !== 16'h0 || sb_err !== 1'b0) begin
      n_err++;
      $display("FAIL collision_mem_data: wre=%b wd3=%h busy=%h err=%b, required 1 c0de 0000 0",
               wre, wd3, busy, sb_err);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    tick(0, 4'd0, 16'h0, 1, 4'd8, 0, 4'd0, 16'h0);
    tick(0, 4'd0, 16'h0, 1, 4'd9, 0, 4'd0, 16'h0);
    tick(0, 4'd0, 16'h0, 1, 4'd10, 0, 4'd0, 16'h0);
    tick(1, 4'd1, 16'h1111, 0, 4'd0, 1, 4'd8, 16'h0808);
    tick(1, 4'd1, 16'h2222, 0, 4'd0, 1, 4'd9, 16'h0909);
    n_vec++;
    if (mem_ready !== 1'b0) begin
      n_err++;
      $display("FAIL bp_full_after_two: mem_ready=%b, required 0", mem_ready);
    end
    tick(1, 4'd1, 16'h3333, 0, 4'd0, 1, 4'd10, 16'h0A0A);
    n_vec++;
    if (mem_ready !== 1'b0 || a3 !== 4'd1 || wd3 !== 16'h3333 || last_push) begin
      n_err++;
      $display("FAIL bp_third_waits: mem_ready=%b a3=%0d wd3=%h, required 0 1 3333", mem_ready, a3, wd3);
    end
    // Full and popping: the third result still must not enter this cycle.
    tick(0, 4'd0, 16'h0, 0, 4'd0, 1, 4'd10, 16'h0A0A);
    n_vec++;
    if (a3 !== 4'd8 || wd3 !== 16'h0808 || mem_ready !== 1'b1) begin
      n_err++;
      $display("FAIL bp_drain0: a3=%0d wd3=%h rdy=%b, required 8 0808 1", a3, wd3, mem_ready);
    end
    tick(0, 4'd0, 16'h0, 0, 4'd0, 1, 4'd10, 16'h0A0A);
    n_vec++;
    if (a3 !== 4'd9 || wd3 !== 16'h0909) begin
      n_err++;
      $display("FAIL bp_drain1: a3=%0d wd3=%h, required 9 0909", a3, wd3);
    end
    idle();
    n_vec++;
    if (wre !== 1'b1 || a3 !== 4'd10 || wd3 !== 16'h0A0A) begin
      n_err++;
      $display("FAIL bp_drain2: wre=%b a3=%0d wd3=%h, required 1 10 0a0a", wre, a3, wd3);
    end
    idle();
    n_vec++;
    if (wre !== 1'b0 || busy !== 16'h0 || sb_err !== 1'b0) begin
      n_err++;
      $display("FAIL bp_empty: wre=%b busy=%h err=%b, required 0 0000 0", wre, busy, sb_err);
    end
  endtask

  task automatic test_scoreboard();
    do_reset();
    tick(0, 4'd0, 16'h0, 1, 4'd6, 0, 4'd0, 16'h0);
    tick(0, 4'd0, 16'h0, 0, 4'd0, 1, 4'd6, 16'h6666);
    tick(0, 4'd0, 16'h0, 1, 4'd6, 0, 4'd0, 16'h0);
    n_vec++;
    if (busy[6] !== 1'b1 || sb_err !== 1'b0 || a3 !== 4'd6) begin
      n_err++;
      $display("FAIL sb_set_wins: busy6=%b err=%b a3=%0d, required 1 0 6", busy[6], sb_err, a3);
    end
    do_reset();
    tick(0, 4'd0, 16'h0, 1, 4'd4, 0, 4'd0, 16'h0);
    tick(0, 4'd0, 16'h0, 1, 4'd4, 0, 4'd0, 16'h0);
    n_vec++;
    if (sb_err !== 1'b1 || busy !== 16'h0010) begin
      n_err++;
      $display("FAIL sb_double_issue: err=%b busy=%h, required 1 0010", sb_err, busy);
    end
    idle();
    n_vec++;
    if (sb_err !== 1'b1) begin
      n_err++;
      $display("FAIL sb_err_sticky: err=%b, required 1", sb_err);
    end
    do_reset();
    tick(0, 4'd0, 16'h0, 0, 4'd0, 1, 4'd11, 16'hBBBB);
    idle();
    n_vec++;
    if (sb_err !== 1'b1 || a3 !== 4'd11 || wre !== 1'b1) begin
      n_err++;
      $display("FAIL sb_orphan_pop: err=%b a3=%0d wre=%b, required 1 11 1", sb_err, a3, wre);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    tick(0, 4'd0, 16'h0, 1, 4'd4, 0, 4'd0, 16'h0);
    tick(1, 4'd1, 16'h1, 1, 4'd5, 1, 4'd4, 16'h4444);
    tick(1, 4'd1, 16'h2, 0, 4'd0, 1, 4'd5, 16'h5555);
    alu_valid = 1'b0; mem_valid = 1'b0; ld_issue = 1'b0;
    n_vec++;
    if (busy !== 16'h0030 || mem_ready !== 1'b0) begin
      n_err++;
      $display("FAIL rstmid_precondition: busy=%h rdy=%b, required 0030 0", busy, mem_ready);
    end
    #2 rst = 1'b1;
    #1;
    model_clear();
    n_vec++;
    if (wre !== 1'b0 || a3 !== 4'd0 || wd3 !== 16'h0 || busy !== 16'h0 || mem_ready !== 1'b1 || sb_err !== 1'b0) begin
      n_err++;
      $display("FAIL rstmid_async: wre=%b a3=%0d wd3=%h busy=%h rdy=%b err=%b, required 0 0 0000 0000 1 0",
               wre, a3, wd3, busy, mem_ready, sb_err);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      idle();
      n_vec++;
      if (wre !== 1'b0 || busy !== 16'h0) begin
        n_err++;
        $display("FAIL rstmid_no_write[%0d]: wre=%b busy=%h, required 0 0000", i, wre, busy);
      end
    end
  endtask

  task automatic check_vs_model(input string tag, input int cyc);
    n_vec++;
    if ({wre, a3, wd3, busy, sb_err, mem_ready} !==
        {e_wre, e_a3, e_wd3, mbusy_vec(), m_err, e_ready()}) begin
      n_err++;
      $display("FAIL %s[%0d]: wre=%b a3=%0d wd3=%h busy=%h err=%b rdy=%b, required %b %0d %h %h %b %b",
               tag, cyc, wre, a3, wd3, busy, sb_err, mem_ready,
               e_wre, e_a3, e_wd3, mbusy_vec(), m_err, e_ready());
    end
  endtask

  // Well-behaved traffic: loads only to idle registers, memory returns only
  // for loads in flight, in issue order.
  task automatic test_random_legal();
    logic [3:0] outq[$];
    bit av, li, mv;
    logic [3:0] ar, lr, mr;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      av = ($urandom_range(0, 9) < 4);
      ar = 4'($urandom); lr = 4'($urandom);
      li = ($urandom_range(0, 1) == 1) && !mbusy[lr];
      mv = (outq.size() > 0) && ($urandom_range(0, 9) < 7);
      mr = (outq.size() > 0) ? outq[0] : 4'd0;
      tick(av, ar, 16'($urandom), li, lr, mv, mr, 16'($urandom));
      if (last_push) void'(outq.pop_front());
      if (li) outq.push_back(lr);
      check_vs_model("rand_legal", c);
    end
  endtask

  task automatic test_random_any();
    do_reset();
    for (int c = 0; c < 200; c++) begin
      tick($urandom_range(0, 2) == 0, 4'($urandom), 16'($urandom),
           $urandom_range(0, 3) == 0, 4'($urandom),
           $urandom_range(0, 1) == 1, 4'($urandom), 16'($urandom));
      check_vs_model("rand_any", c);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_clear();
    test_reset();
    test_alu_only();
    test_load_round_trip();
    test_collision();
    test_backpressure();
    test_scoreboard();
    test_reset_mid();
    test_random_legal();
    test_random_any();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
